dense_sequencer: RTL and testbench

// - Datapath control for the dense (fully-connected) layer. Sits directly downstream of the DENSE register bank.
// - Consumes its configuration (input/output data lengths) and issues input/weight fetch beats to the PE array, NUM_PE output neurons per group.
// - Frames accumulation and hands finished output groups to the writeback path.
// - Returns the derived shape fields (output_wid/hei/ch, weight matrix wid/hei) to the register bank as read-only status.

---
 rtl/dense_pkg.sv | 15 +
 rtl/dense_sequencer_if.sv | 31 +++
 rtl/dense_lane_mask.sv | 21 ++
 rtl/dense_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_dense_sequencer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/dense_pkg.sv
// Shared types and constants for the dense-layer sequencer slice.
package dense_pkg;

  localparam int DENSE_LEN_W  = 16;
  localparam int DENSE_NUM_PE = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } dense_seq_state_e;

endpackage

// File: rtl/dense_sequencer_if.sv
// Fetch-beat and writeback handshakes between the dense sequencer (master)
// and the PE array / writeback path (slave).
interface dense_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int NUM_PE = 4
) ();

  logic              fetch_valid;
  logic              fetch_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [ADDR_W-1:0] w_addr;
  logic              acc_clr;
  logic              acc_last;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [NUM_PE-1:0] out_lane_mask;

  modport master (
    output fetch_valid, in_addr, w_addr, acc_clr, acc_last,
    output out_valid, out_addr, out_lane_mask,
    input  fetch_ready, out_ready
  );

  modport slave (
    input  fetch_valid, in_addr, w_addr, acc_clr, acc_last,
    input  out_valid, out_addr, out_lane_mask,
    output fetch_ready, out_ready
  );

endinterface

// File: rtl/dense_lane_mask.sv
// Valid-lane mask for one output group: lane k is live while base+k < N_out.
module dense_lane_mask
  import dense_pkg::*;
#(
  parameter int NUM_PE = DENSE_NUM_PE,
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0]      base,
  input  logic [DENSE_LEN_W-1:0] n_out,
  output logic [NUM_PE-1:0]      mask
);

  // Compare every lane index against the neuron count in a wide domain.
  always_comb begin
    mask = {NUM_PE{1'b0}};
    for (int k = 0; k < NUM_PE; k++) begin
      mask[k] = (32'(base) + 32'(k)) < 32'(n_out);
    end
  end

endmodule

// File: rtl/dense_sequencer.sv
// Dense-layer sequencer: walks input/weight fetch beats per group of NUM_PE
// neurons, frames accumulation and presents finished groups for writeback.
module dense_sequencer
  import dense_pkg::*;
#(
  parameter int NUM_PE  = DENSE_NUM_PE,
  parameter int ADDR_W  = 16,
  parameter int MAC_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DENSE_LEN_W-1:0] input_data_length,
  input  logic [DENSE_LEN_W-1:0] output_data_length,
  dense_sequencer_if.master      bus,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [DENSE_LEN_W-1:0] output_wid,
  output logic [DENSE_LEN_W-1:0] output_hei,
  output logic [DENSE_LEN_W-1:0] output_ch,
  output logic [DENSE_LEN_W-1:0] wid_weight_matrix,
  output logic [DENSE_LEN_W-1:0] hei_weight_matrix
);

  localparam logic [7:0]        DRAIN_INIT = 8'(MAC_LAT);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PE_STEP    = ADDR_W'(NUM_PE);

  dense_seq_state_e       state_r, state_nxt_s;
  logic [DENSE_LEN_W-1:0] i_r, i_nxt_s, n_in_r, n_in_nxt_s, n_out_r, n_out_nxt_s;
  logic [ADDR_W-1:0]      w_base_r, w_base_nxt_s, w_addr_r, w_addr_nxt_s;
  logic [ADDR_W-1:0]      out_addr_r, out_addr_nxt_s, stride_r, stride_nxt_s, in_addr_r;
  logic [7:0]             drain_r, drain_nxt_s;
  logic                   err_r, err_nxt_s, load_s, zero_len_s, last_beat_s, last_grp_s;
  logic                   fetch_valid_r, acc_clr_r, acc_last_r, out_valid_r, busy_r, done_r;
  logic [NUM_PE-1:0]      mask_s, mask_r;
  logic [DENSE_LEN_W-1:0] st_out_wid_r, st_one_r, st_w_wid_r;

  assign zero_len_s  = (input_data_length == 16'd0) || (output_data_length == 16'd0);
  assign last_beat_s = (i_r == n_in_r - 16'd1);
  assign last_grp_s  = (32'(out_addr_r) + 32'(NUM_PE)) >= 32'(n_out_r);

  // Next-state and counter update logic.
  always_comb begin
    state_nxt_s    = state_r;
    i_nxt_s        = i_r;
    n_in_nxt_s     = n_in_r;
    n_out_nxt_s    = n_out_r;
    w_base_nxt_s   = w_base_r;
    w_addr_nxt_s   = w_addr_r;
    out_addr_nxt_s = out_addr_r;
    stride_nxt_s   = stride_r;
    drain_nxt_s    = drain_r;
    err_nxt_s      = err_r;
    load_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s         = 1'b1;
          n_in_nxt_s     = input_data_length;
          n_out_nxt_s    = output_data_length;
          stride_nxt_s   = ADDR_W'(32'(input_data_length) * 32'(NUM_PE));
          err_nxt_s      = zero_len_s;
          i_nxt_s        = 16'd0;
          w_base_nxt_s   = {ADDR_W{1'b0}};
          w_addr_nxt_s   = {ADDR_W{1'b0}};
          out_addr_nxt_s = {ADDR_W{1'b0}};
          state_nxt_s    = zero_len_s ? ST_DONE : ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (bus.fetch_ready) begin
          if (last_beat_s) begin
            drain_nxt_s = DRAIN_INIT;
            state_nxt_s = (DRAIN_INIT == 8'd0) ? ST_WRITE : ST_DRAIN;
          end else begin
            i_nxt_s      = i_r + 16'd1;
            w_addr_nxt_s = w_addr_r + ADDR_ONE;
          end
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (drain_r <= 8'd1) begin
          state_nxt_s = ST_WRITE;
        end else begin
          drain_nxt_s = drain_r - 8'd1;
        end
      end
      ST_WRITE: begin
        if (!bus.out_ready) begin
          state_nxt_s = ST_WRITE;
        end else if (last_grp_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          out_addr_nxt_s = out_addr_r + PE_STEP;
          w_base_nxt_s   = w_base_r + stride_r;
          w_addr_nxt_s   = w_base_r + stride_r;
          i_nxt_s        = 16'd0;
          state_nxt_s    = ST_FETCH;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  dense_lane_mask #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W)) u_lane_mask (
    .base  (out_addr_nxt_s),
    .n_out (n_out_r),
    .mask  (mask_s)
  );

  // State, counters and registered outputs (decoded from the next state).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      i_r           <= 16'd0;
      n_in_r        <= 16'd0;
      n_out_r       <= 16'd0;
      w_base_r      <= {ADDR_W{1'b0}};
      w_addr_r      <= {ADDR_W{1'b0}};
      out_addr_r    <= {ADDR_W{1'b0}};
      stride_r      <= {ADDR_W{1'b0}};
      in_addr_r     <= {ADDR_W{1'b0}};
      drain_r       <= 8'd0;
      err_r         <= 1'b0;
      fetch_valid_r <= 1'b0;
      acc_clr_r     <= 1'b0;
      acc_last_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      mask_r        <= {NUM_PE{1'b0}};
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      i_r           <= i_nxt_s;
      n_in_r        <= n_in_nxt_s;
      n_out_r       <= n_out_nxt_s;
      w_base_r      <= w_base_nxt_s;
      w_addr_r      <= w_addr_nxt_s;
      out_addr_r    <= out_addr_nxt_s;
      stride_r      <= stride_nxt_s;
      in_addr_r     <= ADDR_W'(i_nxt_s);
      drain_r       <= drain_nxt_s;
      err_r         <= err_nxt_s;
      fetch_valid_r <= (state_nxt_s == ST_FETCH);
      acc_clr_r     <= (state_nxt_s == ST_FETCH) && (i_nxt_s == 16'd0);
      acc_last_r    <= (state_nxt_s == ST_FETCH) && (i_nxt_s == n_in_nxt_s - 16'd1);
      out_valid_r   <= (state_nxt_s == ST_WRITE);
      mask_r        <= (state_nxt_s == ST_WRITE) ? mask_s : {NUM_PE{1'b0}};
      busy_r        <= (state_nxt_s != ST_IDLE);
      done_r        <= (state_nxt_s == ST_DONE);
    end
  end

  // Shape status for the register bank, refreshed on every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_out_wid_r <= 16'd0;
      st_one_r     <= 16'd0;
      st_w_wid_r   <= 16'd0;
    end else if (load_s) begin
      st_out_wid_r <= output_data_length;
      st_one_r     <= 16'd1;
      st_w_wid_r   <= input_data_length;
    end
  end

  assign bus.fetch_valid   = fetch_valid_r;
  assign bus.in_addr       = in_addr_r;
  assign bus.w_addr        = w_addr_r;
  assign bus.acc_clr       = acc_clr_r;
  assign bus.acc_last      = acc_last_r;
  assign bus.out_valid     = out_valid_r;
  assign bus.out_addr      = out_addr_r;
  assign bus.out_lane_mask = mask_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign err               = err_r;
  assign output_wid        = st_out_wid_r;
  assign output_hei        = st_one_r;
  assign output_ch         = st_one_r;
  assign wid_weight_matrix = st_w_wid_r;
  assign hei_weight_matrix = st_out_wid_r;

endmodule

// File: tb/tb_dense_sequencer.sv
// Directed self-checking bench for dense_sequencer (NUM_PE=4, ADDR_W=16, MAC_LAT=3).
module tb_dense_sequencer;
  import dense_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] in_len, out_len;
  logic        busy, done, err;
  logic [15:0] o_wid, o_hei, o_ch, w_wid, w_hei;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int overlap = 0;
  int d0;

  logic [33:0] beats[$];
  logic [19:0] groups[$];
  logic [33:0] exp_b[$];
  logic [19:0] exp_g[$];
  logic        f_stall = 1'b0;
  logic        o_stall = 1'b0;
  logic [33:0] f_prev;
  logic [19:0] o_prev;

  always #5 clk = ~clk;

  dense_sequencer_if #(.ADDR_W(16), .NUM_PE(4)) bus ();

  dense_sequencer #(.NUM_PE(4), .ADDR_W(16), .MAC_LAT(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .input_data_length (in_len),
    .output_data_length(out_len),
    .bus               (bus),
    .busy              (busy),
    .done              (done),
    .err               (err),
    .output_wid        (o_wid),
    .output_hei        (o_hei),
    .output_ch         (o_ch),
    .wid_weight_matrix (w_wid),
    .hei_weight_matrix (w_hei)
  );

  function automatic logic [33:0] bt(input logic [15:0] ia, input logic [15:0] wa,
                                     input logic clr, input logic last);
    return {ia, wa, clr, last};
  endfunction

  function automatic logic [19:0] gp(input logic [15:0] oa, input logic [3:0] m);
    return {oa, m};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_logs(input string tag);
    chk({tag, "_nbeats"}, 64'(beats.size()), 64'(exp_b.size()));
    foreach (exp_b[k])
      chk($sformatf("%s_beat%0d", tag, k),
          64'((k < beats.size()) ? beats[k] : 34'h3_ffff_ffff), 64'(exp_b[k]));
    chk({tag, "_ngroups"}, 64'(groups.size()), 64'(exp_g.size()));
    foreach (exp_g[k])
      chk($sformatf("%s_group%0d", tag, k),
          64'((k < groups.size()) ? groups[k] : 20'hfffff), 64'(exp_g[k]));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  // Runs one layer; rnd stalls fetch randomly and holds out_ready low 5 cycles per group.
  task automatic run_layer(input logic [15:0] nin, input logic [15:0] nout,
                           input bit rnd, input int restart_at);
    int hold;
    int d;
    beats.delete();
    groups.delete();
    in_len = nin;
    out_len = nout;
    bus.fetch_ready = 1'b1;
    bus.out_ready = !rnd;
    d = done_cnt;
    hold = 0;
    pulse_start();
    for (int c = 0; c < 600 && done_cnt == d; c++) begin
      @(posedge clk); #1;
      start = (c == restart_at);
      if (c == restart_at) in_len = nin + 16'd3;
      if (rnd) begin
        bus.fetch_ready = 1'($urandom_range(0, 1));
        if (bus.out_valid) begin
          hold++;
          bus.out_ready = (hold > 5);
        end else begin
          hold = 0;
          bus.out_ready = 1'b0;
        end
      end
    end
    start = 1'b0;
    bus.fetch_ready = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("layer_done_once", 64'(done_cnt - d), 64'd1);
    chk("layer_idle", 64'(busy), 64'd0);
  endtask

  // Passive monitor: logs accepted beats/groups and checks hold-while-stalled.
  always @(negedge clk) begin
    if (f_stall && rst_n)
      chk("fetch_hold", {bus.fetch_valid, bus.in_addr, bus.w_addr, bus.acc_clr, bus.acc_last},
          {1'b1, f_prev});
    if (o_stall && rst_n)
      chk("out_hold", {bus.out_valid, bus.out_addr, bus.out_lane_mask}, {1'b1, o_prev});
    if (bus.fetch_valid && bus.fetch_ready)
      beats.push_back({bus.in_addr, bus.w_addr, bus.acc_clr, bus.acc_last});
    if (bus.out_valid && bus.out_ready)
      groups.push_back({bus.out_addr, bus.out_lane_mask});
    if (done) done_cnt++;
    if (bus.fetch_valid && bus.out_valid) overlap++;
    f_stall = bus.fetch_valid && !bus.fetch_ready;
    f_prev  = {bus.in_addr, bus.w_addr, bus.acc_clr, bus.acc_last};
    o_stall = bus.out_valid && !bus.out_ready;
    o_prev  = {bus.out_addr, bus.out_lane_mask};
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_len = 16'd0;
    out_len = 16'd0;
    bus.fetch_ready = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_status", {o_wid, o_hei, o_ch, w_wid}, 64'd0);
    chk("rst_mask", 64'(bus.out_lane_mask), 64'd0);
    rst_n = 1'b1;

    // N_in=3, N_out=4: one full group
    run_layer(16'd3, 16'd4, 1'b0, -1);
    exp_b = '{bt(16'd0, 16'd0, 1'b1, 1'b0), bt(16'd1, 16'd1, 1'b0, 1'b0),
              bt(16'd2, 16'd2, 1'b0, 1'b1)};
    exp_g = '{gp(16'd0, 4'b1111)};
    check_logs("t1");
    chk("t1_status", {o_wid, o_hei, o_ch, w_wid}, {16'd4, 16'd1, 16'd1, 16'd3});
    chk("t1_w_hei", 64'(w_hei), 64'd4);

    // N_in=2, N_out=6: stride 8, partial second group
    run_layer(16'd2, 16'd6, 1'b0, -1);
    exp_b = '{bt(16'd0, 16'd0, 1'b1, 1'b0), bt(16'd1, 16'd1, 1'b0, 1'b1),
              bt(16'd0, 16'd8, 1'b1, 1'b0), bt(16'd1, 16'd9, 1'b0, 1'b1)};
    exp_g = '{gp(16'd0, 4'b1111), gp(16'd4, 4'b0011)};
    check_logs("t2");

    // N_in=3, N_out=5 with random fetch stalls and slow writeback
    run_layer(16'd3, 16'd5, 1'b1, -1);
    exp_b = '{bt(16'd0, 16'd0, 1'b1, 1'b0), bt(16'd1, 16'd1, 1'b0, 1'b0),
              bt(16'd2, 16'd2, 1'b0, 1'b1), bt(16'd0, 16'd12, 1'b1, 1'b0),
              bt(16'd1, 16'd13, 1'b0, 1'b0), bt(16'd2, 16'd14, 1'b0, 1'b1)};
    exp_g = '{gp(16'd0, 4'b1111), gp(16'd4, 4'b0001)};
    check_logs("t4");

    // N_in=0: error, immediate done, no fetch
    beats.delete();
    d0 = done_cnt;
    in_len = 16'd0;
    out_len = 16'd4;
    pulse_start();
    chk("t5_done_hi", 64'(done), 64'd1);
    chk("t5_err", 64'(err), 64'd1);
    chk("t5_status", {o_wid, w_wid}, {16'd4, 16'd0});
    @(posedge clk); #1;
    chk("t5_done_lo", 64'(done), 64'd0);
    chk("t5_idle", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_err_sticky", 64'(err), 64'd1);
    chk("t5_no_beats", 64'(beats.size()), 64'd0);
    chk("t5_done_once", 64'(done_cnt - d0), 64'd1);

    // N_in=1, N_out=1: clr and last on the single beat; clears err
    run_layer(16'd1, 16'd1, 1'b0, -1);
    exp_b = '{bt(16'd0, 16'd0, 1'b1, 1'b1)};
    exp_g = '{gp(16'd0, 4'b0001)};
    check_logs("t3");
    chk("t3_err_clr", 64'(err), 64'd0);
    chk("t3_status", {o_wid, w_wid, w_hei}, {16'd1, 16'd1, 16'd1});

    // Reset mid-FETCH, then a layer with a start pulse while busy
    in_len = 16'd8;
    out_len = 16'd8;
    pulse_start();
    repeat (2) @(posedge clk);
    #1;
    chk("t6_fetching", 64'(bus.fetch_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_fetch_valid", 64'(bus.fetch_valid), 64'd0);
    chk("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_addr", {bus.in_addr, bus.w_addr, o_wid}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_layer(16'd2, 16'd4, 1'b0, 2);
    exp_b = '{bt(16'd0, 16'd0, 1'b1, 1'b0), bt(16'd1, 16'd1, 1'b0, 1'b1)};
    exp_g = '{gp(16'd0, 4'b1111)};
    check_logs("t6");
    chk("t6_status_kept", 64'(w_wid), 64'd2);

    chk("never_both_valid", 64'(overlap), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
